// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state encodings and default widths for the memory port arbiter.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } state_t;
  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 3;
  localparam int STARVE_CW      = 4;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of D grants made while the I port waits.
// Ports: clk, rst (async, active-high), i_inc (count one D grant),
//        i_clr (I was served; clear has priority), o_at_max (count == STARVE_MAX).
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);
  localparam logic [STARVE_CW-1:0] MAX_V = STARVE_CW'(STARVE_MAX);
  logic [STARVE_CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : (i_inc && !o_at_max) ? r_cnt + STARVE_CW'(1) : r_cnt;
  assign o_at_max = r_cnt == MAX_V;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between the fetch (I) and load/store (D) ports.
// Ports: clk, rst (async, active-high)
//   I side : if_req, if_addr in; if_done (pulse), if_rdata (registered), if_stall out
//   D side : d_req, d_we, d_addr, d_wdata in; d_done (pulse), d_rdata (loads only), d_stall out
//   memory : mem_req, mem_we, mem_addr, mem_wdata out (registered); mem_ack, mem_rdata in
// Optional: define IFETCH_BUF_EN to add a one-entry fetch buffer that serves repeat fetches
//   without touching memory.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t r_state, w_next;
  logic r_mem_req, r_mem_we, r_if_done, r_d_done;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata, w_hit_data;
  logic w_idle, w_i_req, w_d_req, w_i_mem, w_hit, w_grant_i, w_grant_d, w_ack_i, w_ack_d, w_at_max;
`ifdef IFETCH_BUF_EN
  logic r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;

  // Unknown encodings fall through the idle path, where no grant is possible, and recover to IDLE.
  always_comb begin
    w_next = (r_state == ST_IBUSY || r_state == ST_DBUSY) ? (mem_ack ? ST_IDLE : r_state)
           : w_grant_i ? ST_IBUSY : w_grant_d ? ST_DBUSY : ST_IDLE;
  end

  // A port whose done is pulsing is not eligible, so the other port wins the done cycle.
  always_comb begin
    w_idle = r_state == ST_IDLE;
    w_i_req = if_req & ~r_if_done;
    w_d_req = d_req & ~r_d_done;
`ifdef IFETCH_BUF_EN
    w_hit = w_idle & w_i_req & r_buf_valid & (r_buf_addr == if_addr);
    w_hit_data = r_buf_data;
`else
    w_hit = 1'b0;
    w_hit_data = '0;
`endif
    w_i_mem = w_i_req & ~w_hit;
    w_grant_i = w_idle & w_i_mem & (~w_d_req | w_at_max);
    w_grant_d = w_idle & w_d_req & ~(w_i_mem & w_at_max);
    w_ack_i = (r_state == ST_IBUSY) & mem_ack;
    w_ack_d = (r_state == ST_DBUSY) & mem_ack;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mem_req <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_if_done <= 1'b0;
      r_d_done <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_if_done <= w_ack_i | w_hit;
      r_d_done <= w_ack_d;
      if (w_grant_i | w_grant_d) begin
        r_mem_req <= 1'b1;
        r_mem_we <= w_grant_d & d_we;
        r_mem_addr <= w_grant_d ? d_addr : if_addr;
        r_mem_wdata <= w_grant_d ? d_wdata : r_mem_wdata;
      end else if (w_ack_i | w_ack_d) begin
        r_mem_req <= 1'b0;
        r_mem_we <= 1'b0;
      end
      if (w_ack_i | w_hit) r_if_rdata <= w_ack_i ? mem_rdata : w_hit_data;
      if (w_ack_d & ~r_mem_we) r_d_rdata <= mem_rdata;
    end

`ifdef IFETCH_BUF_EN
  // Fills only complete in I_BUSY and invalidations only happen at a grant in IDLE, so they never collide.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else if (w_ack_i) begin
      r_buf_valid <= 1'b1;
      r_buf_addr <= r_mem_addr;
      r_buf_data <= mem_rdata;
    end else if (w_grant_d & d_we & (d_addr == r_buf_addr)) begin
      r_buf_valid <= 1'b0;
    end
`endif

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst(rst),
    .i_inc(w_grant_d & if_req),
    .i_clr(w_grant_i | w_hit),
    .o_at_max(w_at_max)
  );

  assign mem_req = r_mem_req;
  assign mem_we = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_done = r_if_done;
  assign d_done = r_d_done;
  assign if_rdata = r_if_rdata;
  assign d_rdata = r_d_rdata;
  assign if_stall = if_req & ~r_if_done;
  assign d_stall = d_req & ~r_d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter (also covers IFETCH_BUF_EN builds).
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst;
  logic if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata, if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_done, if_stall, d_done, d_stall, mem_req, mem_we;
  int checks = 0, errors = 0, lat = 2, mreq_hi = 0, istall_hi = 0;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;
  gnt_t q_gnt[$];
  logic [31:0] q_if[$], q_d[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] shadow[logic [31:0]];
  logic [31:0] d_last;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] shd_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic eg(input logic we, input logic [31:0] a, input logic [31:0] w);
    q_gnt.push_back('{we, a, w});
  endtask

  task automatic fetch(input logic [31:0] a, output int k);
    q_if.push_back(shd_rd(a));
    if_addr = a;
    if_req = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!if_done && k < 50);
    if_req = 1'b0;
  endtask

  task automatic dacc(input logic we, input logic [31:0] a, input logic [31:0] w, output int k);
    if (we) shadow[a] = w;
    else d_last = shd_rd(a);
    q_d.push_back(d_last);
    d_we = we;
    d_addr = a;
    d_wdata = w;
    d_req = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!d_done && k < 50);
    d_req = 1'b0;
  endtask

  // Memory: acks once mem_req has been high for lat cycles; unwritten words read as addr ^ C0DE0000.
  initial begin : memmodel
    int n;
    n = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        n++;
        if (n >= lat) begin
          mem_ack = 1'b1;
          n = 0;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : mem_addr ^ 32'hC0DE_0000;
        end
      end else n = 0;
    end
  end

  // Scoreboard: every new memory transaction and every done pulse must match the next queued entry.
  initial begin : mon
    logic prev;
    gnt_t g;
    logic [31:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req) mreq_hi++;
        if (if_stall) istall_hi++;
        if (mem_req && !prev) begin
          checks++;
          assert (q_gnt.size() != 0) else begin
            errors++;
            $error("FAIL gnt_unexpected got addr=%h exp no transaction", mem_addr);
          end
          if (q_gnt.size() != 0) begin
            g = q_gnt.pop_front();
            chk("gnt_addr", mem_addr, g.addr);
            chk("gnt_we", {31'b0, mem_we}, {31'b0, g.we});
            if (g.we) chk("gnt_wdata", mem_wdata, g.wdata);
          end
        end
        if (if_done) begin
          checks++;
          assert (q_if.size() != 0) else begin
            errors++;
            $error("FAIL if_done_unexpected got rdata=%h exp no pulse", if_rdata);
          end
          if (q_if.size() != 0) begin
            e = q_if.pop_front();
            chk("if_rdata", if_rdata, e);
          end
        end
        if (d_done) begin
          checks++;
          assert (q_d.size() != 0) else begin
            errors++;
            $error("FAIL d_done_unexpected got rdata=%h exp no pulse", d_rdata);
          end
          if (q_d.size() != 0) begin
            e = q_d.pop_front();
            chk("d_rdata", d_rdata, e);
          end
        end
      end
      prev = mem_req;
    end
  end

  initial begin
    int k, ki, kd;
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_last = '0;
    #12;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_done", {31'b0, if_done}, 32'd0);
    chk("rst_d_done", {31'b0, d_done}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_starve", 32'(dut.u_starve.r_cnt), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    // Lone fetch: two memory cycles, done three cycles after the request.
    mreq_hi = 0; istall_hi = 0;
    eg(1'b0, 32'h40, '0);
    fetch(32'h40, k);
    chk("f1_lat", k, 3);
    chk("f1_mreq_cycles", mreq_hi, 2);
    chk("f1_stall_cycles", istall_hi, 3);
    @(posedge clk); #1;
    // Simultaneous requests: D first, I takes the d_done cycle.
    eg(1'b0, 32'h100, '0);
    eg(1'b0, 32'h44, '0);
    fork
      fetch(32'h44, ki);
      dacc(1'b0, 32'h100, '0, kd);
      begin @(posedge clk); #1; chk("c2_starve_inc", 32'(dut.u_starve.r_cnt), 32'd1); end
    join
    chk("c2_d_lat", kd, 3);
    chk("c2_i_lat", ki, 6);
    chk("c2_starve_clr", 32'(dut.u_starve.r_cnt), 32'd0);
    @(posedge clk); #1;
    // Starvation: I contends and backs off three times, then must win the fourth contest.
    for (int i = 0; i < 3; i++) begin
      eg(1'b0, 32'h104 + 32'(4 * i), '0);
      fork
        dacc(1'b0, 32'h104 + 32'(4 * i), '0, kd);
        begin
          if_addr = 32'h300;
          if_req = 1'b1;
          @(posedge clk); #1;
          if_req = 1'b0;
          chk("s3_starve_cnt", 32'(dut.u_starve.r_cnt), 32'(i + 1));
        end
      join
      @(posedge clk); #1;
    end
    eg(1'b0, 32'h300, '0);
    eg(1'b0, 32'h110, '0);
    fork
      fetch(32'h300, ki);
      dacc(1'b0, 32'h110, '0, kd);
      begin @(posedge clk); #1; chk("s3_starve_clr", 32'(dut.u_starve.r_cnt), 32'd0); end
    join
    chk("s3_i_lat", ki, 3);
    chk("s3_d_lat", kd, 6);
    chk("s3_starve_after_d", 32'(dut.u_starve.r_cnt), 32'd0);
    @(posedge clk); #1;
    // Store leaves d_rdata alone; a load-back returns the stored word.
    eg(1'b1, 32'h200, 32'hDEAD_BEEF);
    dacc(1'b1, 32'h200, 32'hDEAD_BEEF, kd);
    chk("st_lat", kd, 3);
    chk("st_rdata_hold", d_rdata, 32'h0000_0110 ^ 32'hC0DE_0000);
    @(posedge clk); #1;
    eg(1'b0, 32'h200, '0);
    dacc(1'b0, 32'h200, '0, kd);
    chk("ld_back_lat", kd, 3);
    @(posedge clk); #1;
    // Asynchronous reset in the middle of a fetch.
    lat = 6;
    eg(1'b0, 32'h48, '0);
    if_addr = 32'h48;
    if_req = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("r_busy_before", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("r_mem_req", {31'b0, mem_req}, 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    chk("r_if_rdata", if_rdata, 32'd0);
    chk("r_d_rdata", d_rdata, 32'd0);
    chk("r_if_done", {31'b0, if_done}, 32'd0);
    if_req = 1'b0;
    d_last = '0;
    @(negedge clk) rst = 1'b0;
    lat = 2;
    @(posedge clk); #1;
    eg(1'b0, 32'h4C, '0);
    fetch(32'h4C, k);
    chk("r_after_lat", k, 3);
    @(posedge clk); #1;
    // Repeat fetch, then invalidate with a store to the same address.
    eg(1'b0, 32'h40, '0);
    fetch(32'h40, k);
    chk("b_miss_lat", k, 3);
    @(posedge clk); #1;
    mreq_hi = 0;
`ifdef IFETCH_BUF_EN
    fetch(32'h40, k);
    chk("b_hit_lat", k, 1);
    chk("b_hit_no_mem", mreq_hi, 0);
`else
    eg(1'b0, 32'h40, '0);
    fetch(32'h40, k);
    chk("b_refetch_lat", k, 3);
    chk("b_refetch_mem", mreq_hi, 2);
`endif
    @(posedge clk); #1;
    eg(1'b1, 32'h40, 32'h1234_5678);
    dacc(1'b1, 32'h40, 32'h1234_5678, kd);
    @(posedge clk); #1;
    eg(1'b0, 32'h40, '0);
    fetch(32'h40, k);
    chk("b_after_store_lat", k, 3);
    chk("b_after_store_data", if_rdata, 32'h1234_5678);
    @(posedge clk); #1;
    chk("q_gnt_left", q_gnt.size(), 32'd0);
    chk("q_if_left", q_if.size(), 32'd0);
    chk("q_d_left", q_d.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
